// File: rtl/player_controller.sv
`default_nettype none
// ============================================================================
// Module      : player_controller
// Description : Grid-walking player FSM: frame-paced steps gated by an
//               occupancy query, plus a timed chop action.
// Revision    : 1.0 - initial release
// ============================================================================
module player_controller #(
    parameter int MAX_X       = 12,
    parameter int MAX_Y       = 8,
    parameter int START_X     = 1,
    parameter int START_Y     = 1,
    parameter int MOVE_FRAMES = 8,
    parameter int CHOP_FRAMES = 60
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frame_update,
    input  logic       left,
    input  logic       right,
    input  logic       up,
    input  logic       down,
    input  logic       chop,
    input  logic       carry,
    output logic [3:0] tgt_x,
    output logic [3:0] tgt_y,
    output logic       tgt_valid,
    input  logic       tgt_blocked,
    output logic [3:0] player_loc_x,
    output logic [3:0] player_loc_y,
    output logic [1:0] player_direction,
    output logic [1:0] player_state,
    output logic       chop_done
);

    localparam int c_CNT_MAX = ((MOVE_FRAMES > CHOP_FRAMES) ? MOVE_FRAMES : CHOP_FRAMES) - 1;
    localparam int c_CNT_W   = (c_CNT_MAX > 0) ? $clog2(c_CNT_MAX + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_MOVE_LOAD = c_CNT_W'(MOVE_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_CHOP_LOAD = c_CNT_W'(CHOP_FRAMES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [3:0]         c_MAX_X     = 4'(MAX_X);
    localparam logic [3:0]         c_MAX_Y     = 4'(MAX_Y);
    localparam logic [3:0]         c_START_X   = 4'(START_X);
    localparam logic [3:0]         c_START_Y   = 4'(START_Y);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_STEP  = 2'd2;
    localparam logic [1:0] S_CHOP  = 2'd3;

    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    logic [1:0]         r_state, w_state_nxt;
    logic [3:0]         r_loc_x, w_loc_x_nxt;
    logic [3:0]         r_loc_y, w_loc_y_nxt;
    logic [1:0]         r_dir, w_dir_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]         r_tgt_x, w_tgt_x_nxt;
    logic [3:0]         r_tgt_y, w_tgt_y_nxt;
    logic               r_chop_done, w_chop_done_nxt;
    logic               w_query;

    logic               w_btn_any;
    logic [1:0]         w_btn_dir;
    logic [3:0]         w_cand_x;
    logic [3:0]         w_cand_y;
    logic               w_cand_ok;

    // Button priority and the neighbouring cell in the chosen direction.
    always_comb begin
        w_btn_any = up | down | left | right;
        w_btn_dir = up ? c_DIR_UP : down ? c_DIR_DOWN : left ? c_DIR_LEFT : c_DIR_RIGHT;
        w_cand_x  = r_loc_x;
        w_cand_y  = r_loc_y;
        w_cand_ok = 1'b0;
        case (w_btn_dir)
            c_DIR_UP: begin
                w_cand_ok = (r_loc_y != 4'd0);
                w_cand_y  = r_loc_y - 4'd1;
            end
            c_DIR_DOWN: begin
                w_cand_ok = (r_loc_y < c_MAX_Y);
                w_cand_y  = r_loc_y + 4'd1;
            end
            c_DIR_LEFT: begin
                w_cand_ok = (r_loc_x != 4'd0);
                w_cand_x  = r_loc_x - 4'd1;
            end
            default: begin
                w_cand_ok = (r_loc_x < c_MAX_X);
                w_cand_x  = r_loc_x + 4'd1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_loc_x     <= c_START_X;
            r_loc_y     <= c_START_Y;
            r_dir       <= c_DIR_DOWN;
            r_cnt       <= '0;
            r_tgt_x     <= 4'd0;
            r_tgt_y     <= 4'd0;
            r_chop_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_loc_x     <= w_loc_x_nxt;
            r_loc_y     <= w_loc_y_nxt;
            r_dir       <= w_dir_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tgt_x     <= w_tgt_x_nxt;
            r_tgt_y     <= w_tgt_y_nxt;
            r_chop_done <= w_chop_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_loc_x_nxt     = r_loc_x;
        w_loc_y_nxt     = r_loc_y;
        w_dir_nxt       = r_dir;
        w_cnt_nxt       = r_cnt;
        w_tgt_x_nxt     = r_tgt_x;
        w_tgt_y_nxt     = r_tgt_y;
        w_chop_done_nxt = 1'b0;
        w_query         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_update) begin
                    if (chop && !carry) begin
                        w_state_nxt = S_CHOP;
                        w_cnt_nxt   = c_CHOP_LOAD;
                    end else if (w_btn_any) begin
                        w_dir_nxt = w_btn_dir;
                        if (w_cand_ok) begin
                            w_query     = 1'b1;
                            w_tgt_x_nxt = w_cand_x;
                            w_tgt_y_nxt = w_cand_y;
                            w_state_nxt = S_CHECK;
                        end
                    end
                end
            end
            // The occupancy answer arrives exactly here; frame_update is ignored.
            S_CHECK: begin
                if (tgt_blocked) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_loc_x_nxt = r_tgt_x;
                    w_loc_y_nxt = r_tgt_y;
                    w_cnt_nxt   = c_MOVE_LOAD;
                    w_state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                if (frame_update) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end
                end
            end
            default: begin
                if (frame_update) begin
                    if (!chop || carry) begin
                        w_state_nxt = S_IDLE;
                    end else if (r_cnt == '0) begin
                        w_chop_done_nxt = 1'b1;
                        w_state_nxt     = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - c_CNT_ONE;
                    end
                end
            end
        endcase
    end

    // The query is presented in the deciding cycle so the answer lands in CHECK.
    assign tgt_valid        = w_query;
    assign tgt_x            = w_tgt_x_nxt;
    assign tgt_y            = w_tgt_y_nxt;
    assign player_loc_x     = r_loc_x;
    assign player_loc_y     = r_loc_y;
    assign player_direction = r_dir;
    assign chop_done        = r_chop_done;
    assign player_state     = (r_state == S_IDLE) ? 2'd0 : (r_state == S_CHOP) ? 2'd2 : 2'd1;

endmodule
`default_nettype wire
